// File: rtl/cos_pkg.sv
// cos_pkg: shared widths, constants, state encoding and Taylor coefficients for cos_taylor_ctrl
package cos_pkg;
    localparam int Q16_W = 17;
    localparam logic [Q16_W-1:0] ONE = 17'd65536;
    localparam logic [Q16_W-1:0] X_MAX = 17'd92681;
    typedef enum logic [2:0] {IDLE, SQ, MULX2, MULC, ACC, DONE} state_t;
    // index 0 is a dummy so k maps straight onto the table
    localparam logic [8:0][Q16_W-1:0] COEF = {
        17'd273, 17'd360, 17'd496, 17'd728, 17'd1170, 17'd2185, 17'd5461, 17'd32768, 17'd0
    };
endpackage

// File: rtl/cos_coef_rom.sv
// cos_coef_rom: combinational k -> round(65536/((2k-1)(2k))) lookup
module cos_coef_rom
    import cos_pkg::*;
(
    input  logic [3:0]       k,
    output logic [Q16_W-1:0] coef
);
    always_comb coef = (k <= 4'd8) ? COEF[k] : '0;
endmodule

// File: rtl/cos_taylor_ctrl.sv
// cos_taylor_ctrl: Q1.16 cos(x) Taylor sequencer driving one external booth multiplier.
// Optional macro COS_EARLY_EXIT_EN stops the series once a term truncates to zero.
module cos_taylor_ctrl
    import cos_pkg::*;
#(
    parameter int NTERMS  = 5,
    parameter int MUL_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [Q16_W-1:0]  x_in,
    output logic              busy,
    output logic              done,
    output logic              range_err,
    output logic [17:0]       cos_out,
    output logic [Q16_W-1:0]  mul_multiplier,
    output logic [Q16_W-1:0]  mul_multiplicand,
    input  logic [33:0]       mul_sum
);
    localparam int CW = $clog2(MUL_LAT + 1);
    localparam logic [CW-1:0] LAT = CW'(MUL_LAT);
    state_t           state;
    logic [Q16_W-1:0] x2, term, coef, prod;
    logic [17:0]      acc, acc_nx;
    logic [3:0]       k;
    logic [CW-1:0]    cnt;
    logic             last, fin;
    logic             unused_bits;
    cos_coef_rom u_rom (.k(k), .coef(coef));
    assign prod        = mul_sum[32:16];
    assign unused_bits = ^{mul_sum[33], mul_sum[15:0]};
    assign last        = cnt == '0;
    assign acc_nx      = k[0] ? acc - {1'b0, term} : acc + {1'b0, term};
`ifdef COS_EARLY_EXIT_EN
    assign fin = (k == 4'(NTERMS)) || (term == '0);
`else
    assign fin = k == 4'(NTERMS);
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            range_err        <= 1'b0;
            cos_out          <= '0;
            mul_multiplier   <= '0;
            mul_multiplicand <= '0;
            x2               <= '0;
            term             <= '0;
            acc              <= '0;
            k                <= '0;
            cnt              <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    busy <= 1'b1;
                    if (x_in > X_MAX) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        range_err <= 1'b1;
                        cos_out   <= '0;
                    end else begin
                        state            <= SQ;
                        term             <= ONE;
                        acc              <= {1'b0, ONE};
                        k                <= 4'd1;
                        cnt              <= LAT;
                        mul_multiplier   <= x_in;
                        mul_multiplicand <= x_in;
                    end
                end
                SQ: if (last) begin
                    state            <= MULX2;
                    x2               <= prod;
                    cnt              <= LAT;
                    mul_multiplier   <= term;
                    mul_multiplicand <= prod;
                end else cnt <= cnt - 1'b1;
                MULX2: if (last) begin
                    state            <= MULC;
                    cnt              <= LAT;
                    mul_multiplier   <= prod;
                    mul_multiplicand <= coef;
                end else cnt <= cnt - 1'b1;
                MULC: if (last) begin
                    state <= ACC;
                    term  <= prod;
                end else cnt <= cnt - 1'b1;
                ACC: begin
                    acc <= acc_nx;
                    if (fin) begin
                        state            <= DONE;
                        done             <= 1'b1;
                        range_err        <= 1'b0;
                        cos_out          <= acc_nx;
                        mul_multiplier   <= '0;
                        mul_multiplicand <= '0;
                    end else begin
                        state            <= MULX2;
                        k                <= k + 4'd1;
                        cnt              <= LAT;
                        mul_multiplier   <= term;
                        mul_multiplicand <= x2;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cos_taylor_ctrl.sv
// tb_cos_taylor_ctrl: scoreboard bench, default instance plus a MUL_LAT=3 NTERMS=8 instance
module tb_cos_taylor_ctrl;
    import cos_pkg::*;
    localparam int LB = 3;
    localparam int NB = 8;
    typedef struct { logic [17:0] cos; logic err; int lat; int c0; } exp_t;
    logic clk = 1'b0, rst = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0;
    logic [16:0] x_a = '0, x_b = '0;
    logic busy_a, done_a, err_a, busy_b, done_b, err_b;
    logic [17:0] cos_a, cos_b;
    logic [16:0] ma_a, mb_a, ma_b, mb_b;
    logic [33:0] sum_a, sb1, sb2, sum_b;
    int cyc = 0, checks = 0, errors = 0, last_c0 = 0;
    exp_t qa[$], qb[$];
    exp_t ea, eb;
    logic pdone_a = 1'b0;
    state_t pst = IDLE;
    logic [16:0] pa = '0, pb = '0;
    int run = 0;
    logic moved = 1'b0;

    cos_taylor_ctrl dut_a (.clk(clk), .rst(rst), .start(start_a), .x_in(x_a), .busy(busy_a),
        .done(done_a), .range_err(err_a), .cos_out(cos_a), .mul_multiplier(ma_a),
        .mul_multiplicand(mb_a), .mul_sum(sum_a));
    cos_taylor_ctrl #(.NTERMS(NB), .MUL_LAT(LB)) dut_b (.clk(clk), .rst(rst), .start(start_b),
        .x_in(x_b), .busy(busy_b), .done(done_b), .range_err(err_b), .cos_out(cos_b),
        .mul_multiplier(ma_b), .mul_multiplicand(mb_b), .mul_sum(sum_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // booth stand-ins: one register stage for A, three for B
    always @(posedge clk) begin
        sum_a <= 34'(ma_a) * 34'(mb_a);
        sb1   <= 34'(ma_b) * 34'(mb_b);
        sb2   <= sb1;
        sum_b <= sb2;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint coef(input int k);
        longint d = longint'((2 * k - 1) * (2 * k));
        return (65536 + d / 2) / d;
    endfunction

    function automatic exp_t model(input longint x, input int n, input int l);
        exp_t e;
        longint x2, term, p, acc;
        int it = 0;
        e.c0 = 0;
        if (x > 92681) begin
            e.cos = '0; e.err = 1'b1; e.lat = 1;
            return e;
        end
        x2 = (x * x) >> 16; term = 65536; acc = 65536;
        for (int k = 1; k <= n; k++) begin
            p = (term * x2) >> 16;
            term = (p * coef(k)) >> 16;
            acc = (k % 2 == 1) ? acc - term : acc + term;
            it++;
`ifdef COS_EARLY_EXIT_EN
            if (term == 0) break;
`endif
        end
        e.cos = 18'(acc); e.err = 1'b0; e.lat = 1 + (l + 1) + it * (2 * (l + 1) + 1);
        return e;
    endfunction

    task automatic issue_a(input logic [16:0] x);
        exp_t e;
        @(negedge clk);
        start_a = 1'b1; x_a = x;
        e = model(longint'(x), 5, 1); e.c0 = cyc; last_c0 = cyc;
        qa.push_back(e);
        @(negedge clk);
        start_a = 1'b0; x_a = 17'($urandom);
    endtask

    task automatic issue_b(input logic [16:0] x);
        exp_t e;
        @(negedge clk);
        start_b = 1'b1; x_b = x;
        e = model(longint'(x), NB, LB); e.c0 = cyc;
        qb.push_back(e);
        @(negedge clk);
        start_b = 1'b0; x_b = 17'($urandom);
    endtask

    task automatic wait_done(input bit b);
        int n = 0;
        while (!(b ? done_b : done_a) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++; errors++;
            $display("FAIL done_timeout_%s: no done after %0d cycles", b ? "b" : "a", n);
        end
    endtask

    task automatic at_cycle(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && pdone_a) begin
            chk("done_pulse_a", done_a, 0);
            chk("busy_drop_a", busy_a, 0);
        end
        if (!rst && done_a) begin
            if (qa.size() == 0) chk("unexpected_done_a", 1, 0);
            else begin
                ea = qa.pop_front();
                chk("cos_a", cos_a, ea.cos);
                chk("range_err_a", err_a, ea.err);
                chk("latency_a", cyc - ea.c0, ea.lat);
                chk("busy_at_done_a", busy_a, 1);
            end
        end
        pdone_a = done_a && !rst;
        if (!rst && done_b) begin
            if (qb.size() == 0) chk("unexpected_done_b", 1, 0);
            else begin
                eb = qb.pop_front();
                chk("cos_b", cos_b, eb.cos);
                chk("range_err_b", err_b, eb.err);
                chk("latency_b", cyc - eb.c0, eb.lat);
            end
        end
    end

    // each multiply state of B must present one stable operand pair for LB+1 cycles
    always @(negedge clk) begin
        if (rst) run = 0;
        else if (dut_b.state == pst && (pst == SQ || pst == MULX2 || pst == MULC)) begin
            run++;
            if (ma_b != pa || mb_b != pb) moved = 1'b1;
        end else begin
            if (pst == SQ || pst == MULX2 || pst == MULC) begin
                chk("hold_len_b", run, LB + 1);
                chk("hold_stable_b", moved, 0);
            end
            run = 1; moved = 1'b0;
        end
        pst = dut_b.state; pa = ma_b; pb = mb_b;
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_cos", cos_a, 0);
        chk("rst_ops", {ma_a, mb_a}, 0);
        issue_a(17'd65536); wait_done(0);
        chk("cos_of_one", cos_a, 35408);
        issue_a(17'd0); wait_done(0);
        chk("cos_of_zero", cos_a, 65536);
        issue_a(17'd92682); wait_done(0);
        chk("range_flag", err_a, 1);
        issue_a(17'd0); wait_done(0);
        chk("range_cleared", err_a, 0);
        issue_a(17'd65536);
        at_cycle(last_c0 + 5);
        start_a = 1'b1; x_a = 17'($urandom);
        @(negedge clk); start_a = 1'b0;
        at_cycle(last_c0 + 10);
        start_a = 1'b1; x_a = 17'($urandom);
        @(negedge clk); start_a = 1'b0;
        wait_done(0);
        issue_a(17'd40000); wait_done(0);
        issue_a(17'd65536);
        at_cycle(last_c0 + 12);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy_a, 0);
        chk("midrst_done", done_a, 0);
        chk("midrst_cos", cos_a, 0);
        chk("midrst_ops", {ma_a, mb_a}, 0);
        qa.delete();
        rst = 1'b0;
        issue_a(17'd65536); wait_done(0);
        chk("cos_after_rst", cos_a, 35408);
        for (int i = 0; i < 20; i++) begin
            issue_a((i % 5 == 4) ? 17'($urandom_range(92682, 131071)) : 17'($urandom_range(0, 92681)));
            wait_done(0);
        end
        issue_b(17'd92681); wait_done(1);
        issue_b(17'd65536); wait_done(1);
        for (int i = 0; i < 3; i++) begin
            issue_b(17'($urandom_range(0, 92681)));
            wait_done(1);
        end
        repeat (5) @(negedge clk);
        chk("queue_a_empty", qa.size(), 0);
        chk("queue_b_empty", qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
